// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit.
package rv32i_pkg;

    // Major opcodes (ir[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // ALU operation codes driven on alu_sel
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    // ALU operand A source
    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    // ALU operand B source
    localparam logic B_RS2 = 1'b0;
    localparam logic B_IMM = 1'b1;

    // Next-PC source
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_REL    = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    // Register write-back source
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    // funct7 must be all-zero, or 0x20 where the alternate encoding exists
    function automatic logic funct7_ok(input logic [6:0] funct7, input logic alt_ok);
        return (funct7 == 7'h00) || (alt_ok && (funct7 == 7'h20));
    endfunction

endpackage

// File: rtl/rv32i_ctrl_imm_gen.sv
// Combinational immediate generator: picks the I/S/B/U/J layout from the opcode.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] ir,
    output logic [31:0] imm
);

    // Reassemble and sign-extend the immediate for the latched instruction
    always_comb begin
        imm = 32'h0000_0000;
        case (ir[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm = {{20{ir[31]}}, ir[31:20]};
            OPC_STORE:                      imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OPC_BRANCH:                     imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:             imm = {ir[31:12], 12'h000};
            OPC_JAL:                        imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:                        imm = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/rv32i_ctrl.sv
// RV32I multi-cycle control unit: fetch handshake, instruction register,
// decode, and all datapath select/enable lines.
module rv32i_ctrl
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        alu_less,
    input  logic        alu_zero,
    output logic        mem_req,
    output logic        mem_is_fetch,
    output logic        mem_we,
    output logic [3:0]  alu_sel,
    output logic [1:0]  a_sel,
    output logic        b_sel,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        trap
);

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] ir_r;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;

    logic        legal_s;
    logic        is_branch_s;
    logic        is_load_s;
    logic        is_store_s;
    logic        is_jal_s;
    logic        is_jalr_s;
    logic        writes_rd_s;
    logic        taken_s;
    logic [3:0]  alu_code_s;
    logic [1:0]  a_code_s;
    logic        b_code_s;

    assign opcode_s = ir_r[6:0];
    assign funct3_s = ir_r[14:12];
    assign funct7_s = ir_r[31:25];
    // IR resets to ADDI x0,x0,0 so the field outputs read zero before the first fetch
    assign rs1 = ir_r[19:15];
    assign rs2 = ir_r[24:20];
    assign rd  = ir_r[11:7];

    imm_gen u_imm_gen (
        .ir  (ir_r),
        .imm (imm)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Instruction register, loaded on the completing fetch beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r <= 32'h0000_0013;
        end else if ((state_r == ST_FETCH) && mem_ready) begin
            ir_r <= mem_rdata;
        end
    end

    // Instruction decode: legality, class flags, ALU operand selection, branch outcome
    always_comb begin
        legal_s     = 1'b0;
        is_branch_s = 1'b0;
        is_load_s   = 1'b0;
        is_store_s  = 1'b0;
        is_jal_s    = 1'b0;
        is_jalr_s   = 1'b0;
        writes_rd_s = 1'b0;
        taken_s     = 1'b0;
        alu_code_s  = ALU_ADD;
        a_code_s    = A_RS1;
        b_code_s    = B_RS2;
        case (opcode_s)
            OPC_OP: begin
                alu_code_s  = {funct7_s[5], funct3_s};
                writes_rd_s = 1'b1;
                legal_s     = funct7_ok(funct7_s, (funct3_s == 3'b000) || (funct3_s == 3'b101));
            end
            OPC_OP_IMM: begin
                alu_code_s  = {(funct3_s == 3'b101) ? funct7_s[5] : 1'b0, funct3_s};
                b_code_s    = B_IMM;
                writes_rd_s = 1'b1;
                if (funct3_s == 3'b001) begin
                    legal_s = funct7_ok(funct7_s, 1'b0);
                end else if (funct3_s == 3'b101) begin
                    legal_s = funct7_ok(funct7_s, 1'b1);
                end else begin
                    legal_s = 1'b1;
                end
            end
            OPC_LUI: begin
                alu_code_s  = ALU_PASSB;
                b_code_s    = B_IMM;
                writes_rd_s = 1'b1;
                legal_s     = 1'b1;
            end
            OPC_AUIPC: begin
                a_code_s    = A_PC;
                b_code_s    = B_IMM;
                writes_rd_s = 1'b1;
                legal_s     = 1'b1;
            end
            OPC_LOAD: begin
                b_code_s    = B_IMM;
                is_load_s   = 1'b1;
                writes_rd_s = 1'b1;
                legal_s     = 1'b1;
            end
            OPC_STORE: begin
                b_code_s   = B_IMM;
                is_store_s = 1'b1;
                legal_s    = 1'b1;
            end
            OPC_JAL: begin
                is_jal_s    = 1'b1;
                writes_rd_s = 1'b1;
                legal_s     = 1'b1;
            end
            OPC_JALR: begin
                b_code_s    = B_IMM;
                is_jalr_s   = 1'b1;
                writes_rd_s = 1'b1;
                legal_s     = 1'b1;
            end
            OPC_BRANCH: begin
                is_branch_s = 1'b1;
                legal_s     = (funct3_s[2:1] != 2'b01);
                if (funct3_s[2] == 1'b0) begin
                    alu_code_s = ALU_SUB;
                    taken_s    = alu_zero ^ funct3_s[0];
                end else begin
                    alu_code_s = funct3_s[1] ? ALU_SLTU : ALU_SLT;
                    taken_s    = alu_less ^ funct3_s[0];
                end
            end
            OPC_MISC_MEM: begin
                legal_s = 1'b1;
            end
            default: begin
                // SYSTEM and unknown opcodes trap
                legal_s = 1'b0;
            end
        endcase
    end

    // Next-state sequencing
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BOOT: state_next_s = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (legal_s) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_TRAP;
                end
            end
            ST_EXEC: begin
                if (is_branch_s) begin
                    state_next_s = ST_FETCH;
                end else if (is_load_s || is_store_s) begin
                    state_next_s = ST_MEM;
                end else begin
                    state_next_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (!mem_ready) begin
                    state_next_s = ST_MEM;
                end else if (is_store_s) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_WB;
                end
            end
            ST_WB:   state_next_s = ST_FETCH;
            ST_TRAP: state_next_s = ST_TRAP;
            default: state_next_s = ST_TRAP;
        endcase
    end

    // Moore outputs from state + IR; only the store/branch PC strobes look at inputs
    always_comb begin
        mem_req      = 1'b0;
        mem_is_fetch = 1'b0;
        mem_we       = 1'b0;
        alu_sel      = ALU_ADD;
        a_sel        = A_RS1;
        b_sel        = B_RS2;
        rf_we        = 1'b0;
        rf_wsel      = WB_ALU;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        trap         = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_req      = 1'b1;
                mem_is_fetch = 1'b1;
            end
            ST_DECODE: begin
                alu_sel = alu_code_s;
                a_sel   = a_code_s;
                b_sel   = b_code_s;
            end
            ST_EXEC: begin
                alu_sel = alu_code_s;
                a_sel   = a_code_s;
                b_sel   = b_code_s;
                if (is_branch_s) begin
                    pc_we  = 1'b1;
                    pc_sel = taken_s ? PC_REL : PC_PLUS4;
                end else begin
                    pc_we  = 1'b0;
                end
            end
            ST_MEM: begin
                alu_sel = alu_code_s;
                a_sel   = a_code_s;
                b_sel   = b_code_s;
                mem_req = 1'b1;
                mem_we  = is_store_s;
                if (is_store_s && mem_ready) begin
                    pc_we = 1'b1;
                end else begin
                    pc_we = 1'b0;
                end
            end
            ST_WB: begin
                alu_sel = alu_code_s;
                a_sel   = a_code_s;
                b_sel   = b_code_s;
                rf_we   = writes_rd_s && (rd != 5'd0);
                pc_we   = 1'b1;
                if (is_jal_s) begin
                    pc_sel  = PC_REL;
                    rf_wsel = WB_PC4;
                end else if (is_jalr_s) begin
                    pc_sel  = PC_ALU;
                    rf_wsel = WB_PC4;
                end else if (is_load_s) begin
                    pc_sel  = PC_PLUS4;
                    rf_wsel = WB_MEM;
                end else begin
                    pc_sel  = PC_PLUS4;
                    rf_wsel = WB_ALU;
                end
            end
            ST_TRAP: trap = 1'b1;
            default: trap = 1'b0;
        endcase
    end

endmodule
